// File: rtl/instr_loader_pkg.sv
// Shared instruction-memory constants and loader state encoding,
// also imported by the instruction memory.
package instr_loader_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_BYTE_WIDTH = 8;
   localparam int unsigned DEF_MEM_DEPTH  = 32;
   localparam int unsigned DEF_SIZEOP     = 6;

   localparam logic [DEF_SIZEOP-1:0] HALT_OPCODE = 6'b111111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs received bytes MSB-first into a word; word/word_valid present the
// completed word in the same cycle as the final byte strobe.
module word_assembler #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  strobe,
   input  logic [BYTE_WIDTH-1:0] rx_byte,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_valid
);

   localparam int unsigned BYTES = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

   // Only the earlier bytes are stored; the final byte is taken straight from the input.
   logic [DATA_WIDTH-BYTE_WIDTH-1:0] shift;
   logic [CNT_W-1:0]                 count;

   assign word       = {shift, rx_byte};
   assign word_valid = strobe && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         shift <= '0;
         count <= '0;
      end else if (strobe) begin
         shift <= word[DATA_WIDTH-BYTE_WIDTH-1:0];
         count <= word_valid ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Loads a program received byte-wise over UART into instruction memory,
// one registered write strobe per assembled word, until HALT or memory full.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned BYTE_WIDTH = DEF_BYTE_WIDTH,
   parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
   parameter int unsigned SIZEOP     = DEF_SIZEOP
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [BYTE_WIDTH-1:0] i_rx_data,
   input  logic                  i_rx_done,
   output logic [DATA_WIDTH-1:0] o_instruccion,
   output logic [DATA_WIDTH-1:0] o_address,
   output logic                  o_loading,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_overflow
);

   localparam int unsigned ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   state_t state, state_next;

   logic [ADDR_W-1:0]     addr, addr_next;
   logic [DATA_WIDTH-1:0] instr_next;
   logic                  loading_next, busy_next, done_next, overflow_next;

   logic                  accept, clear, halt, at_last;
   logic [DATA_WIDTH-1:0] word;
   logic                  word_valid;

   assign halt    = (o_instruccion[DATA_WIDTH-1 -: SIZEOP] == SIZEOP'(HALT_OPCODE));
   assign at_last = (addr == LAST_ADDR);

   // Kept outside the FSM process: the assembler feeds word_valid back into it.
   assign accept = i_rx_done &&
                   ((state == ST_RECV) || ((state == ST_WRITE) && !halt && !at_last));
   assign clear  = i_start &&
                   ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

   word_assembler #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
   ) u_asm (
      .clk        (i_clock),
      .rst        (i_reset),
      .clear      (clear),
      .strobe     (accept),
      .rx_byte    (i_rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next    = state;
      addr_next     = addr;
      instr_next    = o_instruccion;
      loading_next  = 1'b0;
      done_next     = o_done;
      overflow_next = o_overflow;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_start) begin
               state_next    = ST_RECV;
               addr_next     = '0;
               done_next     = 1'b0;
               overflow_next = 1'b0;
            end
         end
         ST_RECV: begin
            if (word_valid) begin
               state_next   = ST_WRITE;
               instr_next   = word;
               loading_next = 1'b1;
            end
         end
         ST_WRITE: begin
            if (halt) begin
               state_next = ST_DONE;
               done_next  = 1'b1;
            end else if (at_last) begin
               state_next    = ST_ERROR;
               overflow_next = 1'b1;
            end else begin
               state_next = ST_RECV;
               addr_next  = addr + ADDR_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
      busy_next = (state_next == ST_RECV) || (state_next == ST_WRITE);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         addr          <= '0;
         o_instruccion <= '0;
         o_loading     <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         addr          <= addr_next;
         o_instruccion <= instr_next;
         o_loading     <= loading_next;
         o_busy        <= busy_next;
         o_done        <= done_next;
         o_overflow    <= overflow_next;
      end
   end

   assign o_address = {{(DATA_WIDTH-ADDR_W){1'b0}}, addr};

endmodule
